// File: rtl/legv8_cu_pkg.sv
// ============================================================================
//  legv8_cu_pkg
//  Shared definitions for the LEGv8 multi-cycle control unit: control-word
//  field offsets, ALU/PC select codes, FSM states, opcodes, branch conditions.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package legv8_cu_pkg;

  localparam int CW_W       = 34;
  localparam int CW_DA_LSB  = 0;
  localparam int CW_SA_LSB  = 5;
  localparam int CW_SB_LSB  = 10;
  localparam int CW_FS_LSB  = 15;
  localparam int CW_REGW    = 20;
  localparam int CW_RAMW    = 21;
  localparam int CW_EN_MEM  = 22;
  localparam int CW_EN_ALU  = 23;
  localparam int CW_EN_PC   = 24;
  localparam int CW_BSEL    = 25;
  localparam int CW_PS_LSB  = 26;
  localparam int CW_SL      = 28;
  localparam int CW_IL      = 30;
  localparam int CW_NS_LSB  = 31;

  // FS = {op[2:0], invA, invB}
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REG  = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_EXEC2 = 2'b10
  } state_e;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_ANDS  = 11'b11101010000;
  localparam logic [10:0] OP_LSL   = 11'b11010011011;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_BR    = 11'b11010110000;

  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
  localparam logic [9:0]  OP_EORI  = 10'b1101001000;
  localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
  localparam logic [9:0]  OP_ANDIS = 10'b1111001000;

  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OP_MOVK  = 9'b111100101;

  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;

  function automatic logic cond_holds(input logic [3:0] cond,
                                      input logic n, input logic z,
                                      input logic c, input logic v);
    logic r;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_HS: r = c;
      COND_LO: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~(c & ~z);
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = ~(~z & (n == v));
      default: r = 1'b1;  // AL and NV both always
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_legv8_if.sv
// ============================================================================
//  control_unit_legv8_if
//  Instruction/status in, control word/immediate out between the instruction
//  register, the control unit (slave) and the datapath (master).
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_unit_legv8_if;
  import legv8_cu_pkg::*;

  logic [31:0]     instruction;
  logic [4:0]      status;
  logic [CW_W-1:0] ControlWord;
  logic [63:0]     constant;

  modport master (
    output instruction,
    output status,
    input  ControlWord,
    input  constant
  );

  modport slave (
    input  instruction,
    input  status,
    output ControlWord,
    output constant
  );

endinterface

`default_nettype wire

// File: rtl/legv8_cu_decode.sv
// ============================================================================
//  legv8_cu_decode
//  Combinational decode of instruction + status into the EXEC/EXEC2 control
//  word and 64-bit immediate. MOVK second phase exists only with CU_MOVK_EN.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module legv8_cu_decode
  import legv8_cu_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [4:0]      status_i,
  input  logic            exec2_i,
  output logic [CW_W-1:0] word_o,
  output logic [63:0]     const_o
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [8:0]  op9;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd, rn, rm;

  logic [63:0] imm12, shamt, ldst_off, cb_off, br_off, mov_imm;
  logic [5:0]  mov_sh;
  logic        cond_ok;
`ifdef CU_MOVK_EN
  logic [63:0] mov_mask;
`endif

  logic       r_hit, r_sl, i_hit, i_sl;
  logic [4:0] r_fs, i_fs;

  logic [4:0] da, sa, sb, fs;
  logic       regw, ramw, en_mem, en_alu, en_pc, bsel, sl;
  logic [1:0] ps;
  state_e     ns;

  assign op11 = instr_i[31:21];
  assign op10 = instr_i[31:22];
  assign op9  = instr_i[31:23];
  assign op8  = instr_i[31:24];
  assign op6  = instr_i[31:26];
  assign rd   = instr_i[4:0];
  assign rn   = instr_i[9:5];
  assign rm   = instr_i[20:16];

  assign imm12    = {52'd0, instr_i[21:10]};
  assign shamt    = {58'd0, instr_i[15:10]};
  assign ldst_off = {{55{instr_i[20]}}, instr_i[20:12]};
  assign cb_off   = {{43{instr_i[23]}}, instr_i[23:5], 2'b00};
  assign br_off   = {{36{instr_i[25]}}, instr_i[25:0], 2'b00};
  assign mov_sh   = {instr_i[22:21], 4'b0000};
  assign mov_imm  = {48'd0, instr_i[20:5]} << mov_sh;
`ifdef CU_MOVK_EN
  assign mov_mask = ~(64'hFFFF << mov_sh);
`endif

  assign cond_ok = cond_holds(instr_i[3:0], status_i[1], status_i[4],
                              status_i[2], status_i[3]);

  always_comb begin
    r_hit = 1'b1;
    r_sl  = 1'b0;
    r_fs  = FS_ADD;
    case (op11)
      OP_ADD:  r_fs = FS_ADD;
      OP_ADDS: begin r_fs = FS_ADD; r_sl = 1'b1; end
      OP_SUB:  r_fs = FS_SUB;
      OP_SUBS: begin r_fs = FS_SUB; r_sl = 1'b1; end
      OP_AND:  r_fs = FS_AND;
      OP_ANDS: begin r_fs = FS_AND; r_sl = 1'b1; end
      OP_ORR:  r_fs = FS_OR;
      OP_EOR:  r_fs = FS_EOR;
      default: r_hit = 1'b0;
    endcase
  end

  always_comb begin
    i_hit = 1'b1;
    i_sl  = 1'b0;
    i_fs  = FS_ADD;
    case (op10)
      OP_ADDI:  i_fs = FS_ADD;
      OP_ADDIS: begin i_fs = FS_ADD; i_sl = 1'b1; end
      OP_SUBI:  i_fs = FS_SUB;
      OP_SUBIS: begin i_fs = FS_SUB; i_sl = 1'b1; end
      OP_ANDI:  i_fs = FS_AND;
      OP_ANDIS: begin i_fs = FS_AND; i_sl = 1'b1; end
      OP_ORRI:  i_fs = FS_OR;
      OP_EORI:  i_fs = FS_EOR;
      default:  i_hit = 1'b0;
    endcase
  end

  // Longest opcode patterns are tested first so shorter ones cannot shadow them.
  always_comb begin
    da      = '0;
    sa      = '0;
    sb      = '0;
    fs      = FS_AND;
    regw    = 1'b0;
    ramw    = 1'b0;
    en_mem  = 1'b0;
    en_alu  = 1'b0;
    en_pc   = 1'b0;
    bsel    = 1'b0;
    sl      = 1'b0;
    ps      = PS_INC;
    ns      = ST_FETCH;
    const_o = '0;

    if (exec2_i) begin
`ifdef CU_MOVK_EN
      if (op9 == OP_MOVK) begin
        da      = rd;
        sa      = rd;
        fs      = FS_OR;
        bsel    = 1'b1;
        regw    = 1'b1;
        en_alu  = 1'b1;
        const_o = mov_imm;
      end
`endif
    end else if (r_hit) begin
      da     = rd;
      sa     = rn;
      sb     = rm;
      fs     = r_fs;
      sl     = r_sl;
      regw   = 1'b1;
      en_alu = 1'b1;
    end else if (op11 == OP_LSL || op11 == OP_LSR) begin
      da      = rd;
      sa      = rn;
      fs      = (op11 == OP_LSL) ? FS_LSL : FS_LSR;
      regw    = 1'b1;
      en_alu  = 1'b1;
      bsel    = 1'b1;
      const_o = shamt;
    end else if (op11 == OP_LDUR) begin
      da      = rd;
      sa      = rn;
      fs      = FS_ADD;
      bsel    = 1'b1;
      en_mem  = 1'b1;
      regw    = 1'b1;
      const_o = ldst_off;
    end else if (op11 == OP_STUR) begin
      sa      = rn;
      sb      = rd;
      fs      = FS_ADD;
      bsel    = 1'b1;
      ramw    = 1'b1;
      const_o = ldst_off;
    end else if (op11 == OP_BR) begin
      sa = rn;
      ps = PS_REG;
    end else if (i_hit) begin
      da      = rd;
      sa      = rn;
      fs      = i_fs;
      sl      = i_sl;
      regw    = 1'b1;
      en_alu  = 1'b1;
      bsel    = 1'b1;
      const_o = imm12;
    end else if (op9 == OP_MOVZ) begin
      da      = rd;
      sa      = 5'd31;
      fs      = FS_OR;
      bsel    = 1'b1;
      regw    = 1'b1;
      en_alu  = 1'b1;
      const_o = mov_imm;
`ifdef CU_MOVK_EN
    end else if (op9 == OP_MOVK) begin
      // Clear the target halfword now, OR in the new value during EXEC2.
      da      = rd;
      sa      = rd;
      fs      = FS_AND;
      bsel    = 1'b1;
      regw    = 1'b1;
      en_alu  = 1'b1;
      ps      = PS_HOLD;
      ns      = ST_EXEC2;
      const_o = mov_mask;
`endif
    end else if (op8 == OP_CBZ || op8 == OP_CBNZ) begin
      sa      = rd;
      sb      = 5'd31;
      fs      = FS_OR;
      const_o = cb_off;
      // instr[24] is 0 for CBZ, 1 for CBNZ
      if (status_i[0] != instr_i[24]) ps = PS_REL;
    end else if (op8 == OP_BCOND) begin
      const_o = cb_off;
      if (cond_ok) ps = PS_REL;
    end else if (op6 == OP_B) begin
      const_o = br_off;
      ps      = PS_REL;
    end else if (op6 == OP_BL) begin
      const_o = br_off;
      ps      = PS_REL;
      da      = 5'd30;
      en_pc   = 1'b1;
      regw    = 1'b1;
    end
  end

  always_comb begin
    word_o                     = '0;
    word_o[CW_DA_LSB +: 5]     = da;
    word_o[CW_SA_LSB +: 5]     = sa;
    word_o[CW_SB_LSB +: 5]     = sb;
    word_o[CW_FS_LSB +: 5]     = fs;
    word_o[CW_REGW]            = regw;
    word_o[CW_RAMW]            = ramw;
    word_o[CW_EN_MEM]          = en_mem;
    word_o[CW_EN_ALU]          = en_alu;
    word_o[CW_EN_PC]           = en_pc;
    word_o[CW_BSEL]            = bsel;
    word_o[CW_PS_LSB +: 2]     = ps;
    word_o[CW_SL]              = sl;
    word_o[CW_NS_LSB +: 2]     = ns;
  end

endmodule

`default_nettype wire

// File: rtl/control_unit_legv8.sv
// ============================================================================
//  control_unit_legv8
//  LEGv8 multi-cycle control unit: FETCH/EXEC(/EXEC2) state register with
//  reset and FETCH muxing around the combinational decoder.
//  Optional feature macro: CU_MOVK_EN (enables MOVK and the EXEC2 state).
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit_legv8
  import legv8_cu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  control_unit_legv8_if.slave  bus
);

  state_e          state_q, state_d;
  logic [CW_W-1:0] dec_word;
  logic [63:0]     dec_const;
  logic [CW_W-1:0] cw;
  logic [63:0]     k;

  legv8_cu_decode u_decode (
    .instr_i  (bus.instruction),
    .status_i (bus.status),
    .exec2_i  (state_q == ST_EXEC2),
    .word_o   (dec_word),
    .const_o  (dec_const)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Reset forces an all-zero word so an interrupted instruction writes nothing.
  always_comb begin
    cw = '0;
    k  = '0;
    if (!reset) begin
      if (state_q == ST_FETCH) begin
        cw[CW_IL]            = 1'b1;
        cw[CW_NS_LSB +: 2]   = ST_EXEC;
      end else begin
        cw = dec_word;
        k  = dec_const;
      end
    end
  end

  assign state_d         = state_e'(cw[CW_NS_LSB +: 2]);
  assign bus.ControlWord = cw;
  assign bus.constant    = k;

endmodule

`default_nettype wire

// File: tb/tb_control_unit_legv8.sv
// ============================================================================
//  tb_control_unit_legv8
//  Directed-vector bench for control_unit_legv8 with hand-computed words.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit_legv8;

  localparam logic [33:0] FETCH_W = 34'h0C0000000;

  localparam logic [5:0] E_REGW = 6'b000001;
  localparam logic [5:0] E_RAMW = 6'b000010;
  localparam logic [5:0] E_MEM  = 6'b000100;
  localparam logic [5:0] E_ALU  = 6'b001000;
  localparam logic [5:0] E_PC   = 6'b010000;
  localparam logic [5:0] E_BSEL = 6'b100000;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  control_unit_legv8_if bus ();

  control_unit_legv8 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // en = {Bsel, EN_PC, EN_ALU, EN_MEM, ramW, regW}
  function automatic logic [33:0] cw(input logic [4:0] da, input logic [4:0] sa,
                                     input logic [4:0] sb, input logic [4:0] fs,
                                     input logic [5:0] en, input logic [1:0] ps,
                                     input logic sl, input logic [1:0] ns);
    return {1'b0, ns, 1'b0, 1'b0, sl, ps, en, fs, sb, sa, da};
  endfunction

  // Entered just after a rising edge that put the unit in FETCH.
  task automatic exec_vec(input string tag, input logic [31:0] instr, input logic [4:0] st,
                          input logic [33:0] exp_cw, input logic [63:0] exp_k);
    bus.instruction = instr;
    bus.status      = st;
    @(negedge clock);
    check_eq({tag, "/fetch"}, {30'd0, bus.ControlWord}, {30'd0, FETCH_W});
    @(negedge clock);
    check_eq({tag, "/cw"}, {30'd0, bus.ControlWord}, {30'd0, exp_cw});
    check_eq({tag, "/k"}, bus.constant, exp_k);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    bus.instruction = 32'h0;
    bus.status      = 5'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_cw", {30'd0, bus.ControlWord}, 64'd0);
    check_eq("rst_k", bus.constant, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    exec_vec("addi",   32'h91200000, 5'b00000,
             cw(5'd0, 5'd0, 5'd0, 5'b01000, E_REGW | E_ALU | E_BSEL, 2'b01, 1'b0, 2'b00), 64'h800);
    exec_vec("adds",   32'hAB020023, 5'b00000,
             cw(5'd3, 5'd1, 5'd2, 5'b01000, E_REGW | E_ALU, 2'b01, 1'b1, 2'b00), 64'h0);
    exec_vec("subs",   32'hEB0700C5, 5'b00000,
             cw(5'd5, 5'd6, 5'd7, 5'b01001, E_REGW | E_ALU, 2'b01, 1'b1, 2'b00), 64'h0);
    exec_vec("eori",   32'hD23FFC22, 5'b00000,
             cw(5'd2, 5'd1, 5'd0, 5'b01100, E_REGW | E_ALU | E_BSEL, 2'b01, 1'b0, 2'b00), 64'hFFF);
    exec_vec("lsl",    32'hD3601462, 5'b00000,
             cw(5'd2, 5'd3, 5'd0, 5'b10000, E_REGW | E_ALU | E_BSEL, 2'b01, 1'b0, 2'b00), 64'd5);
    exec_vec("ldur",   32'hF8408024, 5'b00000,
             cw(5'd4, 5'd1, 5'd0, 5'b01000, E_REGW | E_MEM | E_BSEL, 2'b01, 1'b0, 2'b00), 64'd8);
    exec_vec("stur",   32'hF81FF049, 5'b00000,
             cw(5'd0, 5'd2, 5'd9, 5'b01000, E_RAMW | E_BSEL, 2'b01, 1'b0, 2'b00), 64'hFFFF_FFFF_FFFF_FFFF);
    exec_vec("movz",   32'hD2A24687, 5'b00000,
             cw(5'd7, 5'd31, 5'd0, 5'b00100, E_REGW | E_ALU | E_BSEL, 2'b01, 1'b0, 2'b00), 64'h1234_0000);
    exec_vec("cbz_t",  32'hB4000065, 5'b00001,
             cw(5'd0, 5'd5, 5'd31, 5'b00100, 6'd0, 2'b11, 1'b0, 2'b00), 64'd12);
    exec_vec("cbz_nt", 32'hB4000065, 5'b00000,
             cw(5'd0, 5'd5, 5'd31, 5'b00100, 6'd0, 2'b01, 1'b0, 2'b00), 64'd12);
    exec_vec("cbz_neg", 32'hB4FFFFE5, 5'b00001,
             cw(5'd0, 5'd5, 5'd31, 5'b00100, 6'd0, 2'b11, 1'b0, 2'b00), 64'hFFFF_FFFF_FFFF_FFFC);
    exec_vec("cbnz_t", 32'hB5000065, 5'b00000,
             cw(5'd0, 5'd5, 5'd31, 5'b00100, 6'd0, 2'b11, 1'b0, 2'b00), 64'd12);
    exec_vec("beq_nt", 32'h54000040, 5'b00000,
             cw(5'd0, 5'd0, 5'd0, 5'b00000, 6'd0, 2'b01, 1'b0, 2'b00), 64'd8);
    exec_vec("beq_t",  32'h54000040, 5'b10000,
             cw(5'd0, 5'd0, 5'd0, 5'b00000, 6'd0, 2'b11, 1'b0, 2'b00), 64'd8);
    exec_vec("bge_nt", 32'h5400004A, 5'b00010,
             cw(5'd0, 5'd0, 5'd0, 5'b00000, 6'd0, 2'b01, 1'b0, 2'b00), 64'd8);
    exec_vec("bge_t",  32'h5400004A, 5'b01010,
             cw(5'd0, 5'd0, 5'd0, 5'b00000, 6'd0, 2'b11, 1'b0, 2'b00), 64'd8);
    exec_vec("bl",     32'h94000001, 5'b00000,
             cw(5'd30, 5'd0, 5'd0, 5'b00000, E_REGW | E_PC, 2'b11, 1'b0, 2'b00), 64'd4);
    exec_vec("b_neg",  32'h17FFFFFF, 5'b00000,
             cw(5'd0, 5'd0, 5'd0, 5'b00000, 6'd0, 2'b11, 1'b0, 2'b00), 64'hFFFF_FFFF_FFFF_FFFC);
    exec_vec("br",     32'hD61F03C0, 5'b00000,
             cw(5'd0, 5'd30, 5'd0, 5'b00000, 6'd0, 2'b10, 1'b0, 2'b00), 64'd0);
    exec_vec("nop",    32'h00000000, 5'b00000,
             cw(5'd0, 5'd0, 5'd0, 5'b00000, 6'd0, 2'b01, 1'b0, 2'b00), 64'd0);

`ifdef CU_MOVK_EN
    bus.instruction = 32'hF2B579A3;
    bus.status      = 5'b00000;
    @(negedge clock);
    check_eq("movk/fetch", {30'd0, bus.ControlWord}, {30'd0, FETCH_W});
    @(negedge clock);
    check_eq("movk/exec", {30'd0, bus.ControlWord},
             {30'd0, cw(5'd3, 5'd3, 5'd0, 5'b00000, E_REGW | E_ALU | E_BSEL, 2'b00, 1'b0, 2'b10)});
    check_eq("movk/exec_k", bus.constant, 64'hFFFF_FFFF_0000_FFFF);
    @(negedge clock);
    check_eq("movk/exec2", {30'd0, bus.ControlWord},
             {30'd0, cw(5'd3, 5'd3, 5'd0, 5'b00100, E_REGW | E_ALU | E_BSEL, 2'b01, 1'b0, 2'b00)});
    check_eq("movk/exec2_k", bus.constant, 64'h0000_0000_ABCD_0000);
    @(posedge clock);
    #1;
`else
    exec_vec("movk_nop", 32'hF2B579A3, 5'b00000,
             cw(5'd0, 5'd0, 5'd0, 5'b00000, 6'd0, 2'b01, 1'b0, 2'b00), 64'd0);
`endif

    // Reset asserted during EXEC must blank the word at once.
    bus.instruction = 32'hF8408024;
    bus.status      = 5'b00000;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check_eq("midrst_cw", {30'd0, bus.ControlWord}, 64'd0);
    check_eq("midrst_k", bus.constant, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    exec_vec("after_rst", 32'h91200000, 5'b00000,
             cw(5'd0, 5'd0, 5'd0, 5'b01000, E_REGW | E_ALU | E_BSEL, 2'b01, 1'b0, 2'b00), 64'h800);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
